// File: rtl/fp_cmp_pkg.sv
// fp_cmp_pkg: op encodings, operand classes and result record shared by the fp_cmp slice
package fp_cmp_pkg;
    localparam logic [1:0] OP_EQ = 2'd0;
    localparam logic [1:0] OP_LT = 2'd1;
    localparam logic [1:0] OP_LE = 2'd2;
    localparam logic [1:0] OP_UN = 2'd3;

    typedef enum logic [2:0] {
        FP_ZERO,
        FP_SUB,
        FP_NORM,
        FP_INF,
        FP_NAN
    } fp_class_e;

    typedef struct packed {
        logic v;
        logic z;
        logic nan;
    } res_t;
endpackage

// File: rtl/fp_cmp_if.sv
// fp_cmp_if: operand/result handshake bundle for fp_cmp (master drives operands, slave returns results)
interface fp_cmp_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;
    logic [W-1:0] cmp_a;
    logic [W-1:0] cmp_b;
    logic [1:0]   cmp_op;
    logic         in_valid;
    logic         in_ready;
    logic         cmp_z;
    logic         cmp_nan;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output cmp_a, cmp_b, cmp_op, in_valid, out_ready,
        input  in_ready, cmp_z, cmp_nan, out_valid
    );

    modport slave (
        input  cmp_a, cmp_b, cmp_op, in_valid, out_ready,
        output in_ready, cmp_z, cmp_nan, out_valid
    );
endinterface

// File: rtl/fp_cmp_classify.sv
// fp_cmp_classify: combinational class decode of an unsigned {exponent, mantissa} field
module fp_cmp_classify
    import fp_cmp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W+MAN_W-1:0] mag,
    output fp_class_e              cls
);
    logic e_ones, e_zero, m_zero;

    assign e_ones = &mag[MAN_W +: EXP_W];
    assign e_zero = ~|mag[MAN_W +: EXP_W];
    assign m_zero = ~|mag[MAN_W-1:0];
    assign cls = e_ones ? (m_zero ? FP_INF : FP_NAN) :
                 e_zero ? (m_zero ? FP_ZERO : FP_SUB) : FP_NORM;
endmodule

// File: rtl/fp_cmp.sv
// fp_cmp: pipelined IEEE-754 compare (EQ/LT/LE/UN) with global stall; FP_CMP_DAZ_EN flushes subnormals to zero
module fp_cmp
    import fp_cmp_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23,
    parameter int STAGES = 2
) (
    input logic     clk,
    input logic     rst,
    fp_cmp_if.slave bus
);
    localparam int W = 1 + EXP_W + MAN_W;
    localparam int N = (STAGES > 1) ? STAGES - 1 : 1;

    fp_class_e    cls_a, cls_b;
    logic         en;
    logic         v0, sa0, sb0, za0, zb0, nan0;
    logic [1:0]   op0;
    logic [W-2:0] ma0, mb0;
    logic         v1, sa1, sb1, za1, zb1, nan1;
    logic [1:0]   op1;
    logic [W-2:0] ma1, mb1;
    logic         eq, lt;
    res_t         res;
    res_t         pipe [N];

    assign en           = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = en;

    fp_cmp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (.mag(bus.cmp_a[W-2:0]), .cls(cls_a));
    fp_cmp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (.mag(bus.cmp_b[W-2:0]), .cls(cls_b));

`ifdef FP_CMP_DAZ_EN
    assign za0 = cls_a inside {FP_ZERO, FP_SUB};
    assign zb0 = cls_b inside {FP_ZERO, FP_SUB};
`else
    assign za0 = cls_a == FP_ZERO;
    assign zb0 = cls_b == FP_ZERO;
`endif

    // zero magnitudes are forced so flushed subnormals order exactly like zero
    assign v0   = bus.in_valid;
    assign op0  = bus.cmp_op;
    assign sa0  = bus.cmp_a[W-1];
    assign sb0  = bus.cmp_b[W-1];
    assign ma0  = za0 ? '0 : bus.cmp_a[W-2:0];
    assign mb0  = zb0 ? '0 : bus.cmp_b[W-2:0];
    assign nan0 = cls_a == FP_NAN || cls_b == FP_NAN;

    generate
        if (STAGES == 1) begin : g_s1_comb
            assign {v1, op1, sa1, sb1, za1, zb1, nan1, ma1, mb1} =
                   {v0, op0, sa0, sb0, za0, zb0, nan0, ma0, mb0};
        end else begin : g_s1_reg
            always_ff @(posedge clk) begin
                if (rst)
                    v1 <= 1'b0;
                else if (en)
                    v1 <= v0;
                if (en)
                    {op1, sa1, sb1, za1, zb1, nan1, ma1, mb1} <= {op0, sa0, sb0, za0, zb0, nan0, ma0, mb0};
            end
        end
    endgenerate

    // sign-magnitude order: opposite signs decide by sign alone, negatives reverse magnitude
    always_comb begin
        eq      = (za1 && zb1) || (sa1 == sb1 && ma1 == mb1);
        lt      = !eq && (sa1 != sb1 ? sa1 : (sa1 ? ma1 > mb1 : ma1 < mb1));
        res.v   = v1;
        res.nan = v1 && nan1;
        res.z   = v1 && (nan1 ? op1 == OP_UN :
                         op1 == OP_EQ ? eq :
                         op1 == OP_LT ? lt :
                         op1 == OP_LE ? (lt || eq) : 1'b0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++)
                pipe[i] <= '0;
        end else if (en) begin
            pipe[0] <= res;
            for (int i = 1; i < N; i++)
                pipe[i] <= pipe[i-1];
        end
    end

    assign bus.out_valid = pipe[N-1].v;
    assign bus.cmp_z     = pipe[N-1].z;
    assign bus.cmp_nan   = pipe[N-1].nan;
endmodule

// File: tb/tb_fp_cmp.sv
// tb_fp_cmp: vector table, stall/reset sequences and random traffic against a real-valued reference model
module tb_fp_cmp;
    import fp_cmp_pkg::*;

    localparam int STAGES = 2;

    typedef struct packed {
        logic z;
        logic n;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic        z;
        logic        n;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   rx_cnt = 0;
    exp_t q[$];
    vec_t vq[$];
    bit   rdone;

    fp_cmp_if #(.EXP_W(8), .MAN_W(23)) bus ();

    fp_cmp #(.EXP_W(8), .MAN_W(23), .STAGES(STAGES)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // value of a binary32 as a real; infinities map beyond any finite float
    function automatic real fval(input logic [31:0] x);
        real m;
        int  e;
        e = int'(x[30:23]);
        if (e == 255)
            m = 1.0e300;
        else if (e == 0)
`ifdef FP_CMP_DAZ_EN
            m = 0.0;
`else
            m = real'(x[22:0]) * (2.0 ** (-149));
`endif
        else
            m = (1.0 + real'(x[22:0]) / 8388608.0) * (2.0 ** (e - 127));
        return x[31] ? -m : m;
    endfunction

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        exp_t r;
        real  va, vb;
        r.n = (a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0);
        va = fval(a);
        vb = fval(b);
        if (r.n)
            r.z = op == 2'd3;
        else
            r.z = op == 2'd0 ? va == vb : op == 2'd1 ? va < vb : op == 2'd2 ? va <= vb : 1'b0;
        return r;
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [31:0] x;
        x = $urandom;
        case ($urandom_range(0, 5))
            0: x[30:23] = 8'h00;
            1: x[30:23] = 8'hFF;
            2: x[30:0]  = '0;
            3: x[30:0]  = 31'h7F800000;
            default: ;
        endcase
        return x;
    endfunction

    function automatic logic [31:0] rnd_b(input logic [31:0] a);
        int sel;
        sel = int'($urandom_range(0, 4));
        return sel == 0 ? a : sel == 1 ? a ^ 32'h80000000 : sel == 2 ? a + 32'd1 : rnd_fp();
    endfunction

    // scoreboard: inputs and outputs sampled at the falling edge, ahead of the transferring rising edge
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                rx_cnt++;
                chk("out_expected", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("out_z", 32'(bus.cmp_z), 32'(e.z));
                    chk("out_nan", 32'(bus.cmp_nan), 32'(e.n));
                end
            end
            if (bus.in_valid && bus.in_ready)
                q.push_back(model(bus.cmp_a, bus.cmp_b, bus.cmp_op));
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        bit ok;
        ok = 0;
        bus.cmp_a    = a;
        bus.cmp_b    = b;
        bus.cmp_op   = op;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
        end
        chk("send_accept", 32'(ok), 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && q.size() != 0; i++)
            @(posedge clk);
        #1;
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic hz, hn;
        int   rx0;
        logic daz_z;
`ifdef FP_CMP_DAZ_EN
        daz_z = 1'b1;
`else
        daz_z = 1'b0;
`endif
        vq.push_back('{32'h80000000, 32'h00000000, OP_EQ, 1'b1, 1'b0});
        vq.push_back('{32'hBF800000, 32'h3F800000, OP_LT, 1'b1, 1'b0});
        vq.push_back('{32'h3F800000, 32'hBF800000, OP_LT, 1'b0, 1'b0});
        vq.push_back('{32'h7FC00000, 32'h7FC00000, OP_UN, 1'b1, 1'b1});
        vq.push_back('{32'h7FC00000, 32'h7FC00000, OP_EQ, 1'b0, 1'b1});
        vq.push_back('{32'h00000001, 32'h00000000, OP_LE, daz_z, 1'b0});
        vq.push_back('{32'hFF800000, 32'hFF7FFFFF, OP_LT, 1'b1, 1'b0});
        vq.push_back('{32'h7F7FFFFF, 32'h7F800000, OP_LT, 1'b1, 1'b0});
        vq.push_back('{32'h3F800000, 32'h40000000, OP_UN, 1'b0, 1'b0});
        vq.push_back('{32'h7F800001, 32'h7F800000, OP_LE, 1'b0, 1'b1});
        vq.push_back('{32'h40000000, 32'h40000000, OP_LE, 1'b1, 1'b0});
        vq.push_back('{32'hC0000000, 32'hBF800000, OP_LT, 1'b1, 1'b0});
        vq.push_back('{32'h00000001, 32'h80000002, OP_EQ, daz_z, 1'b0});
        vq.push_back('{32'h80000000, 32'h00000000, OP_LT, 1'b0, 1'b0});

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.cmp_a     = '0;
        bus.cmp_b     = '0;
        bus.cmp_op    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_z", 32'(bus.cmp_z), 32'd0);
        chk("reset_nan", 32'(bus.cmp_nan), 32'd0);
        rst = 1'b0;
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);

        foreach (vq[i]) begin
            send(vq[i].a, vq[i].b, vq[i].op);
            bus.in_valid = 1'b0;
            chk($sformatf("vec%0d_early", i), 32'(bus.out_valid), 32'd0);
            repeat (STAGES - 1) @(posedge clk);
            #1;
            chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("vec%0d_z", i), 32'(bus.cmp_z), 32'(vq[i].z));
            chk($sformatf("vec%0d_nan", i), 32'(bus.cmp_nan), 32'(vq[i].n));
        end
        drain();

        rx0 = rx_cnt;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    logic [31:0] a;
                    a = rnd_fp();
                    send(a, rnd_b(a), 2'($urandom_range(0, 3)));
                end
                bus.in_valid = 1'b0;
            end
            begin
                repeat (4) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
                    chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
                    if (i > 0) begin
                        chk("stall_hold_z", 32'(bus.cmp_z), 32'(hz));
                        chk("stall_hold_nan", 32'(bus.cmp_nan), 32'(hn));
                    end
                    hz = bus.cmp_z;
                    hn = bus.cmp_nan;
                end
                @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain();
        chk("stall_count", 32'(rx_cnt - rx0), 32'd8);

        rdone = 0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    logic [31:0] a;
                    if ($urandom_range(0, 3) == 0) begin
                        bus.in_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                    a = rnd_fp();
                    send(a, rnd_b(a), 2'($urandom_range(0, 3)));
                end
                bus.in_valid = 1'b0;
                rdone = 1;
            end
            begin
                while (!rdone) begin
                    @(posedge clk);
                    #1 bus.out_ready = $urandom_range(0, 2) != 0;
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();

        bus.out_ready = 1'b0;
        send(32'h3F800000, 32'h40000000, OP_LT);
        send(32'h7FC00000, 32'h3F800000, OP_UN);
        bus.in_valid = 1'b0;
        chk("inflight_valid", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_z", 32'(bus.cmp_z), 32'd0);
        chk("midrst_nan", 32'(bus.cmp_nan), 32'd0);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        chk("postrst_in_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("postrst_no_late", 32'(bus.out_valid), 32'd0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
